// File: rtl/fnd_scan_decoder_if.sv
// Bus bundle between a multiplexed FND display source and the scan decoder.
// The master drives the segment/select lines and consumes the reconstructed frame.
interface fnd_scan_decoder_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   com_n;
  logic                clr_err;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   blank_mask;
  logic                valid;
  logic [1:0]          err;

  modport master (
    output seg_n, com_n, clr_err,
    input  value, blank_mask, valid, err
  );

  modport slave (
    input  seg_n, com_n, clr_err,
    output value, blank_mask, valid, err
  );
endinterface

// File: rtl/fnd_scan_decoder.sv
// Watches an active-low multiplexed 7-segment bus, debounces each digit dwell,
// decodes the pattern back to a nibble and publishes a frame once all digits are seen.
module fnd_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fnd_scan_decoder_if.slave  bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  logic [6:0]          seg_meta_reg, seg_sync_reg;
  logic [DIGITS-1:0]   com_meta_reg, com_sync_reg;

  state_t              state_reg, state_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic [IW-1:0]       lat_idx_reg, lat_idx_next;
  logic [6:0]          lat_seg_reg, lat_seg_next;

  logic [3:0]          shadow_reg [DIGITS];
  logic [DIGITS-1:0]   blank_shadow_reg;
  logic [DIGITS-1:0]   seen_reg, seen_next;
  logic [4*DIGITS-1:0] shadow_flat;

  logic [4*DIGITS-1:0] value_reg;
  logic [DIGITS-1:0]   blank_mask_reg;
  logic                valid_reg;
  logic [1:0]          err_reg, err_next;

  logic [3:0]          sel_cnt;
  logic [IW-1:0]       sel_idx;
  logic                sel_single, sel_multi, same_sample;
  logic                dec_legal, dec_blank;
  logic [3:0]          dec_nib;
  logic                capture, cap_store, cap_illegal, frame_full;
  logic [DIGITS-1:0]   digit_we;

  // Two-flop synchronizers; idle level of both buses is all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta_reg <= '1;
      seg_sync_reg <= '1;
      com_meta_reg <= '1;
      com_sync_reg <= '1;
    end else begin
      seg_meta_reg <= bus.seg_n;
      seg_sync_reg <= seg_meta_reg;
      com_meta_reg <= bus.com_n;
      com_sync_reg <= com_meta_reg;
    end
  end

  always_comb begin
    sel_cnt = '0;
    sel_idx = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (!com_sync_reg[k]) begin
        sel_cnt = sel_cnt + 4'd1;
        sel_idx = IW'(k);
      end
    end
  end

  assign sel_single  = (sel_cnt == 4'd1);
  assign sel_multi   = (sel_cnt > 4'd1);
  assign same_sample = sel_single && (sel_idx == lat_idx_reg) && (seg_sync_reg == lat_seg_reg);

  always_comb begin
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    dec_nib   = 4'h0;
    case (seg_sync_reg)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h58: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h04: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      7'h7F: begin
        dec_legal = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      lat_idx_reg <= '0;
      lat_seg_reg <= '1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      lat_idx_reg <= lat_idx_next;
      lat_seg_reg <= lat_seg_next;
    end
  end

  // The counter holds the number of identical samples seen, including the current one.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    lat_idx_next = lat_idx_reg;
    lat_seg_next = lat_seg_reg;
    capture      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel_single) begin
          state_next   = SETTLE;
          cnt_next     = 8'd1;
          lat_idx_next = sel_idx;
          lat_seg_next = seg_sync_reg;
        end
      end
      SETTLE: begin
        if (!sel_single) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (same_sample) begin
          cnt_next = cnt_reg + 8'd1;
          if (cnt_reg + 8'd1 == STABLE_LIM) begin
            capture    = 1'b1;
            state_next = HELD;
          end
        end else begin
          cnt_next     = 8'd1;
          lat_idx_next = sel_idx;
          lat_seg_next = seg_sync_reg;
        end
      end
      HELD: begin
        if (!sel_single) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (!same_sample) begin
          state_next   = SETTLE;
          cnt_next     = 8'd1;
          lat_idx_next = sel_idx;
          lat_seg_next = seg_sync_reg;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign cap_store   = capture && (dec_legal || dec_blank);
  assign cap_illegal = capture && !dec_legal && !dec_blank;
  assign frame_full  = &seen_reg;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_we[gi]          = cap_store && (sel_idx == IW'(gi));
      assign shadow_flat[4*gi +: 4] = shadow_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DIGITS; k++) shadow_reg[k] <= 4'h0;
      blank_shadow_reg <= '0;
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        if (digit_we[k]) begin
          shadow_reg[k]       <= dec_blank ? 4'h0 : dec_nib;
          blank_shadow_reg[k] <= dec_blank;
        end
      end
    end
  end

  // A full seen mask is published on the following edge and the mask restarts empty.
  assign seen_next = (frame_full ? '0 : seen_reg) | digit_we;

  assign err_next[0] = (err_reg[0] & ~bus.clr_err) | cap_illegal;
  assign err_next[1] = (err_reg[1] & ~bus.clr_err) | sel_multi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_reg       <= '0;
      value_reg      <= '0;
      blank_mask_reg <= '0;
      valid_reg      <= 1'b0;
      err_reg        <= '0;
    end else begin
      seen_reg  <= seen_next;
      valid_reg <= frame_full;
      err_reg   <= err_next;
      if (frame_full) begin
        value_reg      <= shadow_flat;
        blank_mask_reg <= blank_shadow_reg;
      end
    end
  end

  assign bus.value      = value_reg;
  assign bus.blank_mask = blank_mask_reg;
  assign bus.valid      = valid_reg;
  assign bus.err        = err_reg;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Self-checking bench for fnd_scan_decoder: decode table sweep, hand-written
// dwell/reset/error sequences and a randomized dwell stream against a frame model.
module tb_fnd_scan_decoder;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;
  localparam logic [6:0] CODES [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h04, 7'h0E
  };

  typedef struct {
    logic [6:0] seg;
    logic [3:0] nib;
    logic       blank;
    logic       illegal;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [15:0] obs_val [$];
  logic [3:0]  obs_blank [$];

  // Reference model state
  logic [3:0]  m_shadow [DIGITS];
  logic [3:0]  m_blank;
  logic [3:0]  m_seen;
  logic [1:0]  m_err;
  logic [15:0] exp_val [$];
  logic [3:0]  exp_blank [$];

  fnd_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

  fnd_scan_decoder #(
    .DIGITS       (DIGITS),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.valid) begin
      obs_val.push_back(bus.value);
      obs_blank.push_back(bus.blank_mask);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic logic [3:0] sel(input int d);
    logic [3:0] one;
    one = 4'd1;
    return ~(one << d);
  endfunction

  // Returns 0..15 for a digit, 16 for blank, -1 for an illegal pattern.
  function automatic int lookup(input logic [6:0] s);
    if (s == 7'h7F) return 16;
    for (int k = 0; k < 16; k++) if (CODES[k] == s) return k;
    return -1;
  endfunction

  task automatic drive(input logic [3:0] com, input logic [6:0] seg, input int len);
    bus.com_n = com;
    bus.seg_n = seg;
    repeat (len) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int len);
    drive(4'hF, 7'h7F, len);
  endtask

  task automatic do_reset();
    bus.com_n   = 4'hF;
    bus.seg_n   = 7'h7F;
    bus.clr_err = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    obs_val.delete();
    obs_blank.delete();
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_err = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < DIGITS; k++) m_shadow[k] = 4'h0;
    m_blank = '0;
    m_seen  = '0;
    m_err   = '0;
    exp_val.delete();
    exp_blank.delete();
  endtask

  task automatic model_capture(input int d, input logic [6:0] s);
    int c;
    logic [15:0] v;
    c = lookup(s);
    if (c < 0) begin
      m_err[0] = 1'b1;
    end else begin
      m_shadow[d] = (c == 16) ? 4'h0 : 4'(c);
      m_blank[d]  = (c == 16);
      m_seen[d]   = 1'b1;
      if (m_seen == 4'hF) begin
        for (int k = 0; k < DIGITS; k++) v[4*k +: 4] = m_shadow[k];
        exp_val.push_back(v);
        exp_blank.push_back(m_blank);
        m_seen = '0;
      end
    end
  endtask

  task automatic prime_123(input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
    drive(sel(1), s1, 6); idle(1);
    drive(sel(2), s2, 6); idle(1);
    drive(sel(3), s3, 6); idle(1);
  endtask

  initial begin
    vec_t tbl [18];
    int   n;
    logic [3:0] pcom, com;
    logic [6:0] pseg, seg;
    int   kind, d, len, r;

    for (int k = 0; k < 16; k++) tbl[k] = '{CODES[k], 4'(k), 1'b0, 1'b0};
    tbl[16] = '{7'h7F, 4'h0, 1'b1, 1'b0};
    tbl[17] = '{7'h7E, 4'h0, 1'b0, 1'b1};

    bus.com_n   = 4'hF;
    bus.seg_n   = 7'h7F;
    bus.clr_err = 1'b0;
    @(posedge clk);
    #1;
    check("reset_value", 32'(bus.value), 32'h0);
    check("reset_blank", 32'(bus.blank_mask), 32'h0);
    check("reset_valid", 32'(bus.valid), 32'h0);
    check("reset_err",   32'(bus.err), 32'h0);

    // Basic scan: 30,02,0E,40 on digits 0..3
    do_reset();
    drive(sel(0), 7'h30, 8); idle(2);
    drive(sel(1), 7'h02, 8); idle(2);
    drive(sel(2), 7'h0E, 8); idle(2);
    drive(sel(3), 7'h40, 8); idle(8);
    check("scan_frames", 32'(obs_val.size()), 32'd1);
    if (obs_val.size() > 0) begin
      check("scan_value", 32'(obs_val[0]), 32'h0F63);
      check("scan_blank", 32'(obs_blank[0]), 32'h0);
    end
    check("scan_err", 32'(bus.err), 32'h0);

    // Short dwell on digit 1 must not capture
    do_reset();
    drive(sel(0), 7'h30, 8); idle(2);
    drive(sel(1), 7'h02, 3); idle(2);
    drive(sel(2), 7'h0E, 8); idle(2);
    drive(sel(3), 7'h40, 8); idle(8);
    check("short_no_valid", 32'(obs_val.size()), 32'd0);
    drive(sel(1), 7'h02, 4); idle(8);
    check("short_then_4", 32'(obs_val.size()), 32'd1);
    if (obs_val.size() > 0) check("short_value", 32'(obs_val[0]), 32'h0F63);

    // Latency: digits 1..3 primed, then digit 0 held; valid after STABLE+3 edges
    do_reset();
    prime_123(7'h79, 7'h24, 7'h30);
    idle(4);
    bus.com_n = sel(0);
    bus.seg_n = 7'h19;
    n = 0;
    while (!bus.valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency_edges", 32'(n), 32'(STABLE + 3));
    idle(8);
    check("latency_frames", 32'(obs_val.size()), 32'd1);

    // Multiple selects: sticky err[1], clr only effective once condition ends
    do_reset();
    drive(4'b1100, 7'h40, 5); idle(4);
    check("multi_err", 32'(bus.err), 32'h2);
    check("multi_no_frame", 32'(obs_val.size()), 32'd0);
    drive(4'b1100, 7'h40, 3);
    pulse_clr();
    drive(4'b1100, 7'h40, 2); idle(4);
    check("multi_clr_during", 32'(bus.err), 32'h2);
    pulse_clr();
    check("multi_clr_after", 32'(bus.err), 32'h0);

    // Long dwell captures once; mid-dwell code change overwrites
    do_reset();
    prime_123(7'h24, 7'h30, 7'h19);
    drive(sel(0), 7'h40, 50); idle(8);
    check("long_frames", 32'(obs_val.size()), 32'd1);
    if (obs_val.size() > 0) check("long_value", 32'(obs_val[0]), 32'h4320);
    drive(sel(0), 7'h79, 20);
    drive(sel(0), 7'h24, 20); idle(2);
    prime_123(7'h24, 7'h30, 7'h19);
    idle(8);
    check("overwrite_frames", 32'(obs_val.size()), 32'd2);
    if (obs_val.size() > 1) check("overwrite_value", 32'(obs_val[1]), 32'h4322);

    // Mid-operation reset discards partial frame
    do_reset();
    drive(sel(0), 7'h30, 8); idle(2);
    drive(sel(1), 7'h02, 8); idle(2);
    drive(sel(2), 7'h0E, 8); idle(2);
    do_reset();
    drive(sel(3), 7'h40, 8); idle(8);
    check("rst_no_valid", 32'(obs_val.size()), 32'd0);
    check("rst_value", 32'(bus.value), 32'h0);

    // Decode table sweep on digit 0
    for (int t = 0; t < 18; t++) begin
      do_reset();
      prime_123(7'h79, 7'h24, 7'h30);
      drive(sel(0), tbl[t].seg, 6); idle(8);
      if (tbl[t].illegal) begin
        check($sformatf("tbl%0d_frames", t), 32'(obs_val.size()), 32'd0);
        check($sformatf("tbl%0d_err", t), 32'(bus.err), 32'h1);
        drive(sel(0), 7'h40, 6); idle(8);
        check($sformatf("tbl%0d_recover", t), 32'(obs_val.size()), 32'd1);
      end else begin
        check($sformatf("tbl%0d_frames", t), 32'(obs_val.size()), 32'd1);
        if (obs_val.size() > 0) begin
          check($sformatf("tbl%0d_value", t), 32'(obs_val[0]), 32'h3210 | 32'(tbl[t].nib));
          check($sformatf("tbl%0d_blank", t), 32'(obs_blank[0]), 32'(tbl[t].blank));
        end
        check($sformatf("tbl%0d_err", t), 32'(bus.err), 32'h0);
      end
    end

    // Randomized dwell stream against the frame-level model
    do_reset();
    model_reset();
    pcom = 4'hF;
    pseg = 7'h7F;
    for (int it = 0; it < 250; it++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 6) begin
        d = $urandom_range(0, 3);
        r = $urandom_range(0, 19);
        if (r < 16) seg = CODES[r];
        else if (r < 18) seg = 7'h7F;
        else seg = 7'($urandom);
        com = sel(d);
        len = $urandom_range(1, 9);
        if (com == pcom && seg == pseg) idle(1);
        drive(com, seg, len);
        if (len >= STABLE) model_capture(d, seg);
      end else if (kind <= 8) begin
        com = 4'hF;
        seg = 7'($urandom);
        drive(com, seg, $urandom_range(1, 4));
      end else begin
        do com = 4'($urandom); while ($countones(~com) < 2);
        seg = 7'($urandom);
        drive(com, seg, $urandom_range(1, 3));
        m_err[1] = 1'b1;
      end
      pcom = com;
      pseg = seg;
    end
    idle(8);
    check("rand_frames", 32'(obs_val.size()), 32'(exp_val.size()));
    for (int k = 0; k < exp_val.size() && k < obs_val.size(); k++) begin
      check($sformatf("rand_value%0d", k), 32'(obs_val[k]), 32'(exp_val[k]));
      check($sformatf("rand_blank%0d", k), 32'(obs_blank[k]), 32'(exp_blank[k]));
    end
    check("rand_err", 32'(bus.err), 32'(m_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fnd_scan_decoder.md
Name: fnd_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-7-segment driver: monitors a multiplexed, active-low, common-select FND bus and reconstructs the hex nibble shown on each digit.
- Used for loopback self-check of display paths and for capturing display content from external boards.
- Synchronizes and debounces the bus, decodes segment patterns back to nibbles, and assembles a full frame. Publishes the frame with a valid pulse once every digit has been captured.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a capture (2..255).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- seg_n  input  7  segment lines, active-low, bit6=g … bit0=a.
- com_n  input  DIGITS  digit selects, active-low; bit i selects digit i.
- clr_err  input  1  synchronous one-cycle clear of err.
- value  output  4*DIGITS  assembled frame; digit i in bits [4i+3:4i].
- blank_mask  output  DIGITS  bit i = 1 when digit i was blank in the last frame.
- valid  output  1  one-cycle pulse when value/blank_mask update.
- err  output  2  sticky flags: bit0 illegal segment pattern, bit1 multiple selects active.

Behaviour:
- Reset (async, rst_n=0) values:
  - value=0, blank_mask=0, valid=0, err=0.
  - Synchronizer flops all 1s; stability counter 0; seen mask 0; state IDLE.
- Input synchronization: seg_n and com_n pass through 2-flop synchronizers. All logic below uses the synchronized copies.
- Select classification, each cycle:
  - No com_n bit low → "none".
  - Exactly one bit low → "single", with index i.
  - Two or more bits low → "multi".
- Decode table (seg_n → nibble):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 58→7.
  - 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 04→E, 0E→F (hex).
  - 7F = blank.
  - Any other pattern is illegal.
- State machine:
  - IDLE: select none/multi. On single → SETTLE; counter=1; latch {i, seg}.
  - SETTLE: each cycle compare current {i, seg} with the latched value.
    - Equal: counter+1.
    - Different: re-latch, counter=1.
    - Select becomes none or multi: → IDLE, counter=0.
    - Counter reaches STABLE_CYCLES: perform capture, → HELD.
  - HELD: stays while {i, seg} is unchanged, so exactly one capture per dwell. On any change: → SETTLE (single) or IDLE (none/multi).
- Capture actions:
  - Legal code: shadow[i]=nibble, blank_shadow[i]=0, seen[i]=1.
  - Blank: shadow[i]=0, blank_shadow[i]=1, seen[i]=1.
  - Illegal: err[0]=1; shadow and seen unchanged.
- Multi: err[1] is set in every cycle the classification is multi.
- Frame completion:
  - In the cycle after the capture that makes seen all 1s: value=shadow, blank_mask=blank_shadow, valid=1 for one cycle, seen cleared.
  - A recapture of an already-seen digit overwrites its shadow slot; it does not count twice.
- Latency: bus stable from cycle t → capture at t+2+STABLE_CYCLES-1 → valid in the following cycle.
- err handling:
  - Sticky until clr_err.
  - If clr_err coincides with a new error event, that error bit ends set.
- Mid-operation reset: all state returns to reset values immediately; no partial frame is published after release.
- Digit index order is free: digits may be scanned in any order. The frame completes whenever every digit has been captured at least once since the last valid.

Test Plan:
- Scan digits 0..3 with codes 30, 02, 0E, 40; dwell 8 cycles each, 2 idle cycles between → one valid pulse, value=16'h0F63, blank_mask=0, err=0.
- Digit 1 dwell of only 3 cycles (STABLE_CYCLES=4) inside an otherwise good scan → no capture for digit 1, no valid. A later 4-cycle dwell on digit 1 completes the frame.
- Digit 2 shows 7F → value nibble 2 = 0, blank_mask=4'b0100. Digit 3 shows 7E → err=2'b01, no valid until digit 3 shows a legal code.
- com_n=4'b1100 held 5 cycles → err[1]=1, no capture. clr_err while the condition persists → err[1] stays 1. clr_err after it ends → err=0.
- Single-digit dwell of 50 cycles → exactly one capture. Change seg_n mid-dwell from 79 to 24 → second capture overwrites the nibble with 2.
- Assert rst_n=0 after 3 of 4 digits are captured, then release and scan only digit 3 → no valid. value remains 0 until a full scan completes.
